// File: rtl/ms_input_arbiter.sv
// ms_input_arbiter
//   Round-robin arbiter that merges FLUX independent input streams into the
//   single write port of a multi-stream FIFO. Each accepted word is tagged
//   with its stream index and presented one cycle after the handshake.
//
//   A stream is eligible when it has a word, its FIFO lane is not full, and
//   the word currently on the write port is not for the same stream. The
//   last check stops a stream from winning two cycles in a row while its
//   full flag still reflects the previous occupancy, so a lane with one free
//   slot never overflows.
//
// Ports
//   clk        : single clock, rising edge
//   rst        : synchronous, active-high reset
//   in_data    : FLUX payload words, stream i at [i*DATA_WIDTH +: DATA_WIDTH]
//   in_valid   : per-stream word available
//   in_ready   : per-stream accept (combinational, one-hot or zero)
//   din        : {tag, payload} to the FIFO write port
//   write      : FIFO write strobe, din valid when high
//   full       : per-stream FIFO full flags
//   grant_cnt  : per-stream 16-bit accepted-word counters, stream i at [i*16 +: 16]
module ms_input_arbiter #(
    parameter int  DATA_WIDTH = 32,
    parameter int  FLUX       = 4,
    localparam int ID_W       = $clog2(FLUX)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [FLUX*DATA_WIDTH-1:0]   in_data,
    input  logic [FLUX-1:0]              in_valid,
    output logic [FLUX-1:0]              in_ready,
    output logic [DATA_WIDTH+ID_W-1:0]   din,
    output logic                         write,
    input  logic [FLUX-1:0]              full,
    output logic [FLUX*16-1:0]           grant_cnt
);

    // After reset the pointer sits on the last stream so that the first
    // search begins at stream 0.
    localparam logic [ID_W-1:0] LAST_INIT = ID_W'(FLUX - 1);

    // Round-robin search starting one past the previous winner.
    // Returns {found, index}.
    function automatic logic [ID_W:0] rr_pick(input logic [FLUX-1:0] elig,
                                              input logic [ID_W-1:0] last);
        logic            hit;
        logic [ID_W-1:0] sel;
        logic [ID_W-1:0] cand;
        int              idx;
        hit = 1'b0;
        sel = '0;
        for (int k = 1; k <= FLUX; k++) begin
            idx = int'(last) + k;
            if (idx >= FLUX) begin
                idx = idx - FLUX;
            end
            cand = ID_W'(idx);
            if (!hit && elig[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
        return {hit, sel};
    endfunction

    // Grant counters wrap naturally from 0xFFFF to 0x0000.
    function automatic logic [15:0] cnt_inc(input logic [15:0] c);
        return c + 16'd1;
    endfunction

    logic [DATA_WIDTH-1:0] word_p0 [FLUX];
    logic [FLUX-1:0]       elig_p0;
    logic [ID_W:0]         pick_p0;
    logic                  gnt_vld_p0;
    logic [ID_W-1:0]       gnt_id_p0;
    logic [ID_W-1:0]       last_grant;

    logic                  vld_p1;
    logic [ID_W-1:0]       tag_p1;
    logic [DATA_WIDTH-1:0] data_p1;
    logic [FLUX*16-1:0]    cnt_q;

    // ---- stage p0: eligibility and round-robin selection ----
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            word_p0[i] = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            // A word already on the write port for this stream has not yet
            // been reflected in full[], so hold the stream off one cycle.
            elig_p0[i] = in_valid[i] & ~full[i] &
                         ~(vld_p1 && (tag_p1 == ID_W'(i)));
        end
    end

    assign pick_p0    = rr_pick(elig_p0, last_grant);
    assign gnt_vld_p0 = pick_p0[ID_W] & ~rst;
    assign gnt_id_p0  = pick_p0[ID_W-1:0];

    always_comb begin
        in_ready = '0;
        if (gnt_vld_p0) begin
            in_ready[gnt_id_p0] = 1'b1;
        end
    end

    // ---- stage p1: registered write port and per-stream counters ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1     <= 1'b0;
            tag_p1     <= '0;
            data_p1    <= '0;
            last_grant <= LAST_INIT;
            cnt_q      <= '0;
        end else begin
            vld_p1 <= gnt_vld_p0;
            if (gnt_vld_p0) begin
                tag_p1     <= gnt_id_p0;
                data_p1    <= word_p0[gnt_id_p0];
                last_grant <= gnt_id_p0;
                for (int i = 0; i < FLUX; i++) begin
                    if (gnt_id_p0 == ID_W'(i)) begin
                        cnt_q[i*16 +: 16] <= cnt_inc(cnt_q[i*16 +: 16]);
                    end
                end
            end
        end
    end

    assign write     = vld_p1;
    assign din       = {tag_p1, data_p1};
    assign grant_cnt = cnt_q;

endmodule
